// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo storage element.
// Sizing derivations, default almost-levels and the even-parity function.
package fifo_pkg;

   localparam int unsigned DefaultAemptyLevel = 2;
   // almost_full default sits this many entries below DEPTH
   localparam int unsigned DefaultAfullMargin = 2;

   function automatic int unsigned depth_of(input int unsigned addr_size);
      return 32'd1 << addr_size;
   endfunction

   // Extra MSB is the wrap bit that separates full from empty
   function automatic int unsigned ptr_width(input int unsigned addr_size);
      return addr_size + 1;
   endfunction

   function automatic int unsigned afull_default(input int unsigned addr_size);
      return depth_of(addr_size) - DefaultAfullMargin;
   endfunction

   // Callers zero-extend; zeros do not change the XOR reduction
   function automatic logic even_parity(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/fifo_dpram.sv
// 1W/1R storage array: synchronous write, combinational read by address.
module fifo_dpram
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ADDR_SIZE = 4
) (
   input  logic                 wclk,
   input  logic                 we,
   input  logic [ADDR_SIZE-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [ADDR_SIZE-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);

   localparam int unsigned DEPTH = depth_of(ADDR_SIZE);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge wclk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and sticky error flags.
// Optional per-entry even parity is enabled by defining SYNC_FIFO_PARITY_EN.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_SIZE    = 8,
   parameter int unsigned ADDR_SIZE    = 4,
   parameter int unsigned AFULL_LEVEL  = afull_default(ADDR_SIZE),
   parameter int unsigned AEMPTY_LEVEL = DefaultAemptyLevel
) (
   input  logic                   wclk,
   input  logic                   wrst,
   input  logic                   winc,
   input  logic [DATA_SIZE-1:0]   wdata,
   input  logic                   rinc,
   output logic [DATA_SIZE-1:0]   rdata,
   output logic                   rvalid,
   output logic                   wfull,
   output logic                   rempty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [ADDR_SIZE:0]     count,
   output logic                   overflow,
   output logic                   underflow
`ifdef SYNC_FIFO_PARITY_EN
   ,
   output logic                   perr,
   output logic                   perr_sticky
`endif
);

   localparam int unsigned DEPTH = depth_of(ADDR_SIZE);
   localparam int unsigned PW    = ptr_width(ADDR_SIZE);
`ifdef SYNC_FIFO_PARITY_EN
   localparam int unsigned MW    = DATA_SIZE + 1;
`else
   localparam int unsigned MW    = DATA_SIZE;
`endif

   localparam logic [PW-1:0] DepthCnt  = PW'(DEPTH);
   localparam logic [PW-1:0] AfullLvl  = PW'(AFULL_LEVEL);
   localparam logic [PW-1:0] AemptyLvl = PW'(AEMPTY_LEVEL);

   logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
   logic [DATA_SIZE-1:0] rdata_q;
   logic                 rvalid_q, overflow_q, underflow_q;
   logic                 push_ok, pop_ok;
   logic [MW-1:0]        mem_wdata, mem_rdata;

   // A push into a full FIFO is legal when a pop frees the slot on the same edge
   always_comb begin
      push_ok = winc && (!wfull || rinc);
      pop_ok  = rinc && !rempty;
   end

   always_comb begin
      wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop_ok  ? rptr_q + PW'(1) : rptr_q;
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + PW'(1);
         2'b01:   count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      wfull        = (count_q == DepthCnt);
      rempty       = (count_q == '0);
      almost_full  = (count_q >= AfullLvl);
      almost_empty = (count_q <= AemptyLvl);
      count        = count_q;
      rdata        = rdata_q;
      rvalid       = rvalid_q;
      overflow     = overflow_q;
      underflow    = underflow_q;
   end

`ifdef SYNC_FIFO_PARITY_EN
   assign mem_wdata = {even_parity(64'(wdata)), wdata};
`else
   assign mem_wdata = wdata;
`endif

   fifo_dpram #(
      .WIDTH     (MW),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_mem (
      .wclk  (wclk),
      .we    (push_ok),
      .waddr (wptr_q[ADDR_SIZE-1:0]),
      .wdata (mem_wdata),
      .raddr (rptr_q[ADDR_SIZE-1:0]),
      .rdata (mem_rdata)
   );

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         rvalid_q <= pop_ok;
         if (pop_ok) begin
            rdata_q <= mem_rdata[DATA_SIZE-1:0];
         end
         if (winc && !push_ok) begin
            overflow_q <= 1'b1;
         end
         if (rinc && rempty) begin
            underflow_q <= 1'b1;
         end
      end
   end

`ifdef SYNC_FIFO_PARITY_EN
   logic perr_q, perr_sticky_q, rd_perr;

   assign rd_perr = even_parity(64'(mem_rdata[DATA_SIZE-1:0])) != mem_rdata[DATA_SIZE];

   always_ff @(posedge wclk) begin
      if (wrst) begin
         perr_q        <= 1'b0;
         perr_sticky_q <= 1'b0;
      end else begin
         perr_q <= pop_ok && rd_perr;
         if (pop_ok && rd_perr) begin
            perr_sticky_q <= 1'b1;
         end
      end
   end

   assign perr        = perr_q;
   assign perr_sticky = perr_sticky_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (parity checks built when SYNC_FIFO_PARITY_EN is set).
module tb_sync_fifo;

   logic       wclk = 1'b0;
   logic       wrst, winc, rinc;
   logic [7:0] wdata, rdata;
   logic       rvalid, wfull, rempty, almost_full, almost_empty, overflow, underflow;
   logic [4:0] count;
`ifdef SYNC_FIFO_PARITY_EN
   logic       perr, perr_sticky;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 wclk = ~wclk;

   sync_fifo u_dut (
      .wclk         (wclk),
      .wrst         (wrst),
      .winc         (winc),
      .wdata        (wdata),
      .rinc         (rinc),
      .rdata        (rdata),
      .rvalid       (rvalid),
      .wfull        (wfull),
      .rempty       (rempty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
`ifdef SYNC_FIFO_PARITY_EN
      ,
      .perr         (perr),
      .perr_sticky  (perr_sticky)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle 1ns past it before sampling
   task automatic step();
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset();
      wrst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = '0;
      step();
      step();
      wrst = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      winc = 1'b1; rinc = 1'b0; wdata = d;
      step();
      winc = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] exp);
      winc = 1'b0; rinc = 1'b1;
      step();
      rinc = 1'b0;
      check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
      check({tag, "_rdata"}, 32'(rdata), 32'(exp));
   endtask

   initial begin
      do_reset();
      check("rst_count", 32'(count), 32'd0);
      check("rst_rempty", 32'(rempty), 32'd1);
      check("rst_wfull", 32'(wfull), 32'd0);
      check("rst_aempty", 32'(almost_empty), 32'd1);
      check("rst_afull", 32'(almost_full), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_unf", 32'(underflow), 32'd0);

      // Fill: almost_full from 14, almost_empty through 2
      for (int i = 1; i <= 16; i++) begin
         push(8'(i));
         check("fill_count", 32'(count), 32'(i));
         check("fill_afull", 32'(almost_full), 32'(i >= 14));
         check("fill_aempty", 32'(almost_empty), 32'(i <= 2));
         check("fill_wfull", 32'(wfull), 32'(i == 16));
      end
      check("fill_ovf", 32'(overflow), 32'd0);

      push(8'hAA);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd16);

      for (int i = 1; i <= 16; i++) begin
         pop_expect("drain", 8'(i));
         check("drain_count", 32'(count), 32'(16 - i));
      end
      step();
      check("idle_rvalid", 32'(rvalid), 32'd0);
      check("idle_rdata_hold", 32'(rdata), 32'h10);
      check("drain_rempty", 32'(rempty), 32'd1);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Full with simultaneous push and pop
      for (int i = 1; i <= 16; i++) push(8'(i));
      winc = 1'b1; rinc = 1'b1; wdata = 8'h55;
      step();
      winc = 1'b0; rinc = 1'b0;
      check("fullrw_rdata", 32'(rdata), 32'h01);
      check("fullrw_rvalid", 32'(rvalid), 32'd1);
      check("fullrw_count", 32'(count), 32'd16);
      for (int i = 2; i <= 16; i++) pop_expect("fullrw_pop", 8'(i));
      pop_expect("fullrw_last", 8'h55);
      check("fullrw_empty", 32'(rempty), 32'd1);

      // Empty with push and pop: pop rejected, push accepted
      winc = 1'b1; rinc = 1'b1; wdata = 8'h33;
      step();
      winc = 1'b0; rinc = 1'b0;
      check("unf_flag", 32'(underflow), 32'd1);
      check("unf_rvalid", 32'(rvalid), 32'd0);
      check("unf_count", 32'(count), 32'd1);
      check("unf_rdata_hold", 32'(rdata), 32'h55);
      pop_expect("unf_next", 8'h33);

      // Wrap: 40 push/pop pairs at occupancy 1
      push(8'h80);
      for (int k = 0; k < 40; k++) begin
         winc = 1'b1; rinc = 1'b1; wdata = 8'(8'h81 + k);
         step();
         check("wrap_rdata", 32'(rdata), 32'(8'(8'h80 + k)));
         check("wrap_count", 32'(count), 32'd1);
         check("wrap_rempty", 32'(rempty), 32'd0);
         check("wrap_wfull", 32'(wfull), 32'd0);
      end
      winc = 1'b0; rinc = 1'b0;
      pop_expect("wrap_tail", 8'hA8);
      check("unf_sticky", 32'(underflow), 32'd1);

      // Reset mid-stream overrides a concurrent push
      push(8'h11);
      push(8'h22);
      wrst = 1'b1; winc = 1'b1; wdata = 8'h99;
      step();
      wrst = 1'b0; winc = 1'b0;
      check("mrst_count", 32'(count), 32'd0);
      check("mrst_rdata", 32'(rdata), 32'd0);
      check("mrst_ovf", 32'(overflow), 32'd0);
      check("mrst_unf", 32'(underflow), 32'd0);
      push(8'h44);
      pop_expect("mrst_first", 8'h44);

`ifdef SYNC_FIFO_PARITY_EN
      do_reset();
      for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
      u_dut.u_mem.mem[3][0] = ~u_dut.u_mem.mem[3][0];
      for (int i = 0; i < 6; i++) begin
         pop_expect("par_pop", (i == 3) ? 8'h12 : 8'(8'h10 + i));
         check("par_perr", 32'(perr), 32'(i == 3));
         check("par_sticky", 32'(perr_sticky), 32'(i >= 3));
      end
      step();
      check("par_sticky_hold", 32'(perr_sticky), 32'd1);
      do_reset();
      check("par_sticky_rst", 32'(perr_sticky), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO: the next generation of the team's FIFO storage element. It integrates the storage array with the write/read pointers, occupancy counter, full/empty/almost flags and sticky error flags. Read data is registered. It serves same-clock buffering between pipeline stages, where the dual-clock FIFO is not needed.

Parameters:
DATA_SIZE, 8, width of each data word in bits
ADDR_SIZE, 4, address width; DEPTH = 1 << ADDR_SIZE entries
AFULL_LEVEL, DEPTH-2, almost_full asserts when count >= AFULL_LEVEL
AEMPTY_LEVEL, 2, almost_empty asserts when count <= AEMPTY_LEVEL

Ports:
wclk  in  1  single clock, rising edge
wrst  in  1  synchronous, active-high reset
winc  in  1  push request
wdata  in  DATA_SIZE  push data
rinc  in  1  pop request
rdata  out  DATA_SIZE  registered pop data
rvalid  out  1  rdata holds the word popped on the previous edge
wfull  out  1  count == DEPTH
rempty  out  1  count == 0
almost_full  out  1  count >= AFULL_LEVEL
almost_empty  out  1  count <= AEMPTY_LEVEL
count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a push was rejected
underflow  out  1  sticky: a pop was rejected

Behaviour:
- Reset: on a wclk edge with wrst=1, clear all state: wptr=rptr=0, count=0, rdata=0, rvalid=0, overflow=0, underflow=0. Resulting flags: rempty=1, wfull=0, almost_empty=1, almost_full=0. Memory contents are not cleared. Reset overrides winc/rinc in the same cycle.
- Pointers are ADDR_SIZE+1 bits wide. The low ADDR_SIZE bits address memory; the MSB is the wrap bit. Pointers wrap naturally modulo 2*DEPTH.
- Acceptance is evaluated on pre-edge state:
  - push_ok = winc && (!wfull || rinc)
  - pop_ok = rinc && !rempty
- Push accepted: mem[wptr] <= wdata; wptr increments.
- Pop accepted: rdata <= mem[rptr] (pre-write value); rptr increments; rvalid <= 1.
- No pop accepted: rvalid <= 0 and rdata holds its value.
- Read latency: one cycle from the rinc edge to valid rdata.
- count updates: +1 on push only, -1 on pop only, unchanged on both or neither.
- All flags (wfull, rempty, almost_full, almost_empty) are combinational decodes of the registered count.
- Full + winc + rinc: both accepted, count stays DEPTH. rdata returns the oldest word, not wdata.
- Full + winc without rinc: push dropped, overflow <= 1, memory and pointers unchanged.
- Empty + rinc: pop rejected, underflow <= 1, rvalid <= 0. A push in the same cycle is still accepted, so no read-through: the pushed data is not visible until the next pop.
- overflow and underflow clear only on wrst.
- Wrap: after 2*DEPTH accepted pushes and pops, pointers return to 0 with no flag glitch.
- Reset asserted mid-stream discards all content; the first rdata after reset comes from the first post-reset push.

Optional Feature:
Macro: SYNC_FIFO_PARITY_EN
- Defined: each entry stores DATA_SIZE+1 bits, with even parity of wdata as the extra bit. On each accepted pop, parity is recomputed on the read word. Added output perr (1 bit) pulses high alongside rvalid on a mismatch. Added output perr_sticky holds until wrst.
- Undefined: memory is DATA_SIZE wide, and perr/perr_sticky do not exist.

Decomposition:
- Shared package fifo_pkg holds:
  - DEPTH derivation helper (1 << ADDR_SIZE)
  - pointer-width constant (ADDR_SIZE+1)
  - default almost-level constants
  - the even-parity function, used by both write and check paths
- One natural sub-module, fifo_dpram: 1W/1R synchronous-write array.
  - Write gated by a write enable; read is combinational by address.
  - sync_fifo registers the read output itself.
  - Pointer, count and flag logic stay in sync_fifo.

Test Plan:
- Reset, then push 0x01..0x10 (16 words) → wfull=1 and count=16 after the 16th edge; almost_full first asserts at count=14; overflow stays 0.
- From full, push 0xAA with rinc=0 → overflow=1, count=16; the following 16 pops return 0x01..0x10 in order, each with rvalid one cycle after rinc, and never 0xAA.
- From full, winc=1 + rinc=1 with wdata 0x55 → rdata=0x01, count stays 16; the 16th subsequent pop returns 0x55.
- From empty, rinc=1 with winc=1 (wdata 0x33) → underflow=1, rvalid=0, count=1; the next pop returns 0x33.
- Run 40 push/pop pairs at count=1 (pointers wrap twice) → data order preserved, rempty/wfull never spuriously asserted, and count holds 1 after each pair's edge.
- With parity enabled, force-flip a stored bit at address 3, then pop it → perr=1 with rvalid and perr_sticky=1 held until wrst; other words show perr=0.
